// File: rtl/uart_fmt_pkg.sv
// uart_fmt_pkg: ASCII constants, FSM state encoding and the
// "ERROR" message ROM shared by the number formatter.
package uart_fmt_pkg;

  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;
  localparam logic [7:0] ASC_0  = 8'h30;
  localparam logic [7:0] ASC_E  = 8'h45;
  localparam logic [7:0] ASC_R  = 8'h52;
  localparam logic [7:0] ASC_O  = 8'h4F;

  // "ERROR" + CR + LF
  localparam int ERR_LEN = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  function automatic logic [7:0] err_byte(
    input logic [2:0] i
  );
    logic [7:0] b;
    case (i)
      3'd0:    b = ASC_E;
      3'd1:    b = ASC_R;
      3'd2:    b = ASC_R;
      3'd3:    b = ASC_O;
      3'd4:    b = ASC_R;
      3'd5:    b = ASC_CR;
      default: b = ASC_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: iterative shift-add-3 binary to BCD, one bit per cycle.
// Ports: clk, reset, start, value in; done pulse, bcd (saturated to 9s).
module bin2bcd_seq
  import uart_fmt_pkg::*;
#(
  parameter int DATA_W     = 9,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       value,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);

  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d, adj;
  logic              ovf_q, ovf_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // A 1 shifted out of the top digit means the value
  // no longer fits; partial values only grow, so sticky.
  always_comb begin
    bin_d = bin_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (start) begin
      bin_d = value;
      bcd_d = '0;
      ovf_d = 1'b0;
      cnt_d = CW'(DATA_W);
    end else if (cnt_q != '0) begin
      bcd_d = {adj[BW-2:0], bin_q[DATA_W-1]};
      bin_d = bin_q << 1;
      ovf_d = ovf_q | adj[BW-1];
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == CW'(1));
  assign bcd  = ovf_q ? {NUM_DIGITS{4'd9}} : bcd_q;

endmodule

// File: rtl/uart_num_formatter.sv
// uart_num_formatter: value -> "<digits><u0><u1>\r\n" bytes to a TX FIFO.
// In: clk reset tick start error value fifo_full; out: tx_data we busy.
// UART_NUM_FORMATTER_ERRMSG_EN enables the "ERROR\r\n" path.
module uart_num_formatter
  import uart_fmt_pkg::*;
#(
  parameter int          DATA_W     = 9,
  parameter int          NUM_DIGITS = 3,
  parameter logic [7:0]  UNIT0      = 8'h63,
  parameter logic [7:0]  UNIT1      = 8'h6D
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              start,
  input  logic              error,
  input  logic [DATA_W-1:0] value,
  input  logic              fifo_full,
  output logic [7:0]        tx_data,
  output logic              we,
  output logic              busy
);

  localparam int ND = NUM_DIGITS;
  localparam int NB = (ND + 4 > ERR_LEN) ? ND + 4 : ERR_LEN;
  localparam int IW = $clog2(NB + 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      tx_q, tx_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic            err_sel, accept, qual;
  logic            conv_done;
  logic [4*ND-1:0] bcd;
  logic [NB-1:0]   valid;
  logic            seen;
  logic [IW-1:0]   cur, last_idx;
  logic            last;
  logic [7:0]      byte_v;

`ifdef UART_NUM_FORMATTER_ERRMSG_EN
  assign err_sel = error;
`else
  logic unused_err;
  assign unused_err = error;
  assign err_sel    = 1'b0;
`endif

  assign accept = (state_q == ST_IDLE) && start;
  assign qual   = tick && !fifo_full;

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (ND)
  ) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (accept && !err_sel),
    .value (value),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Which byte slots exist in the message: leading zeros
  // are dropped, zero-valued unit bytes are dropped.
  always_comb begin
    valid = '0;
    seen  = 1'b0;
    if (err_q) begin
      for (int i = 0; i < ERR_LEN; i++)
        valid[i] = 1'b1;
    end else begin
      for (int i = 0; i < ND; i++) begin
        seen = seen |
          (bcd[4*(ND-1-i) +: 4] != 4'd0);
        valid[i] = seen | (i == ND - 1);
      end
      valid[ND]   = (UNIT0 != 8'h00);
      valid[ND+1] = (UNIT1 != 8'h00);
      valid[ND+2] = 1'b1;
      valid[ND+3] = 1'b1;
    end
  end

  // cur = first existing slot at or after idx_q
  always_comb begin
    last_idx = IW'(err_q ? ERR_LEN - 1 : ND + 3);
    cur      = last_idx;
    for (int i = NB - 1; i >= 0; i--) begin
      if (valid[i] && i >= int'(idx_q))
        cur = IW'(i);
    end
    last = (cur == last_idx);
  end

  always_comb begin
    byte_v = ASC_LF;
    for (int i = 0; i < ND; i++) begin
      if (cur == IW'(i))
        byte_v = ASC_0 +
          {4'h0, bcd[4*(ND-1-i) +: 4]};
    end
    if (cur == IW'(ND))     byte_v = UNIT0;
    if (cur == IW'(ND + 1)) byte_v = UNIT1;
    if (cur == IW'(ND + 2)) byte_v = ASC_CR;
`ifdef UART_NUM_FORMATTER_ERRMSG_EN
    if (err_q) byte_v = err_byte(cur[2:0]);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (start)
          state_d = err_sel ? ST_SEND : ST_CONV;
      ST_CONV:
        if (conv_done) state_d = ST_SEND;
      ST_SEND:
        if (qual && last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    err_d = err_q;
    tx_d  = tx_q;
    we_d  = 1'b0;
    if (accept) begin
      err_d = err_sel;
      idx_d = '0;
    end
    if (state_q == ST_SEND && qual) begin
      we_d  = 1'b1;
      tx_d  = byte_v;
      idx_d = last ? '0 : cur + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
      err_q <= 1'b0;
      tx_q  <= 8'h00;
      we_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      err_q <= err_d;
      tx_q  <= tx_d;
      we_q  <= we_d;
    end
  end

  assign tx_data = tx_q;
  assign we      = we_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_num_formatter.sv
// tb_uart_num_formatter: directed vectors on three formatter builds
// (default, DATA_W=10, no unit bytes).
module tb_uart_num_formatter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b1;
  logic       error = 1'b0;
  logic       fifo_full = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic       start2 = 1'b0;
  logic [9:0] value = '0;
  logic [7:0] tx0, tx1, tx2;
  logic       we0, we1, we2;
  logic       busy0, busy1, busy2;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  int         nvec = 0;
  int         nerr = 0;
  int         tick_div = 1;
  int         tcnt = 0;

  uart_num_formatter u0 (
    .clk(clk), .reset(reset), .tick(tick),
    .start(start0), .error(error),
    .value(value[8:0]), .fifo_full(fifo_full),
    .tx_data(tx0), .we(we0), .busy(busy0)
  );

  uart_num_formatter #(.DATA_W(10)) u1 (
    .clk(clk), .reset(reset), .tick(tick),
    .start(start1), .error(error),
    .value(value), .fifo_full(fifo_full),
    .tx_data(tx1), .we(we1), .busy(busy1)
  );

  uart_num_formatter #(
    .UNIT0(8'h00), .UNIT1(8'h00)
  ) u2 (
    .clk(clk), .reset(reset), .tick(tick),
    .start(start2), .error(error),
    .value(value[8:0]), .fifo_full(fifo_full),
    .tx_data(tx2), .we(we2), .busy(busy2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    tcnt = tcnt + 1;
    tick = (tick_div <= 1) ? 1'b1 : ((tcnt % tick_div) == 0);
  end

  always @(negedge clk) begin
    if (we0) q0.push_back(tx0);
    if (we1) q1.push_back(tx1);
    if (we2) q2.push_back(tx2);
  end

  function automatic logic bsy(input int inst);
    case (inst)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic string qs(input int inst);
    string s;
    s = "";
    case (inst)
      0: foreach (q0[i]) s = {s, $sformatf("%c", q0[i])};
      1: foreach (q1[i]) s = {s, $sformatf("%c", q1[i])};
      default:
         foreach (q2[i]) s = {s, $sformatf("%c", q2[i])};
    endcase
    return s;
  endfunction

  function automatic string hx(input string s);
    string r;
    r = "";
    for (int i = 0; i < s.len(); i++)
      r = {r, $sformatf("%02h ", s[i])};
    return r;
  endfunction

  task automatic do_start(input int inst,
                          input logic [9:0] v,
                          input logic e);
    @(negedge clk);
    value = v;
    error = e;
    case (inst)
      0:       start0 = 1'b1;
      1:       start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    value  = ~v;
    error  = ~e;
  endtask

  task automatic wait_idle(input int inst, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bsy(inst) == 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    nvec++;
    if (tx0 !== 8'h00) begin
      nerr++;
      $display("FAIL rst_tx got=%h exp=00", tx0);
    end
    nvec++;
    if (we0 !== 1'b0) begin
      nerr++;
      $display("FAIL rst_we got=%b exp=0", we0);
    end
    nvec++;
    if (busy0 !== 1'b0) begin
      nerr++;
      $display("FAIL rst_busy got=%b exp=0", busy0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({busy0, busy1, busy2, we1, we2} !== 5'b0) begin
      nerr++;
      $display("FAIL idle_after_rst got=%b exp=00000",
               {busy0, busy1, busy2, we1, we2});
    end
  endtask

  task automatic test_zero;
    bit ok;
    string s;
    q0.delete();
    do_start(0, 10'd0, 1'b0);
    wait_idle(0, ok);
    s = qs(0);
    nvec++;
    if (!ok || s != "0cm\015\012") begin
      nerr++;
      $display("FAIL zero ok=%b got=%s exp=30 63 6d 0d 0a",
               ok, hx(s));
    end
    repeat (5) @(negedge clk);
    nvec++;
    if (tx0 !== 8'h0A || we0 !== 1'b0) begin
      nerr++;
      $display("FAIL hold got=%h/%b exp=0a/0", tx0, we0);
    end
  endtask

  task automatic test_values;
    bit ok;
    string s;
    int lat;
    q0.delete();
    do_start(0, 10'd105, 1'b0);
    lat = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (we0) begin
        lat = k;
        break;
      end
    end
    nvec++;
    if (lat != 10) begin
      nerr++;
      $display("FAIL latency got=%0d exp=10", lat);
    end
    wait_idle(0, ok);
    s = qs(0);
    nvec++;
    if (!ok || s != "105cm\015\012") begin
      nerr++;
      $display("FAIL v105 ok=%b got=%s exp=31 30 35 63 6d 0d 0a",
               ok, hx(s));
    end
    q0.delete();
    do_start(0, 10'd511, 1'b0);
    wait_idle(0, ok);
    s = qs(0);
    nvec++;
    if (!ok || s != "511cm\015\012") begin
      nerr++;
      $display("FAIL v511 ok=%b got=%s exp=35 31 31 63 6d 0d 0a",
               ok, hx(s));
    end
    tick_div = 3;
    q0.delete();
    do_start(0, 10'd7, 1'b0);
    wait_idle(0, ok);
    s = qs(0);
    nvec++;
    if (!ok || s != "7cm\015\012") begin
      nerr++;
      $display("FAIL v7_sparse ok=%b got=%s exp=37 63 6d 0d 0a",
               ok, hx(s));
    end
    tick_div = 1;
    q0.delete();
    do_start(0, 10'd60, 1'b0);
    wait_idle(0, ok);
    s = qs(0);
    nvec++;
    if (!ok || s != "60cm\015\012") begin
      nerr++;
      $display("FAIL v60 ok=%b got=%s exp=36 30 63 6d 0d 0a",
               ok, hx(s));
    end
  endtask

  task automatic test_error;
    bit ok;
    string s;
    string exp;
`ifdef UART_NUM_FORMATTER_ERRMSG_EN
    exp = "ERROR\015\012";
`else
    exp = "42cm\015\012";
`endif
    q0.delete();
    do_start(0, 10'd42, 1'b1);
    wait_idle(0, ok);
    s = qs(0);
    nvec++;
    if (!ok || s != exp) begin
      nerr++;
      $display("FAIL error_msg ok=%b got=%s exp=%s",
               ok, hx(s), hx(exp));
    end
    error = 1'b0;
  endtask

  task automatic test_clamp;
    bit ok;
    string s;
    q1.delete();
    do_start(1, 10'd1000, 1'b0);
    wait_idle(1, ok);
    s = qs(1);
    nvec++;
    if (!ok || s != "999cm\015\012") begin
      nerr++;
      $display("FAIL clamp1000 ok=%b got=%s exp=39 39 39 63 6d 0d 0a",
               ok, hx(s));
    end
    q1.delete();
    do_start(1, 10'd999, 1'b0);
    wait_idle(1, ok);
    s = qs(1);
    nvec++;
    if (!ok || s != "999cm\015\012") begin
      nerr++;
      $display("FAIL v999 ok=%b got=%s exp=39 39 39 63 6d 0d 0a",
               ok, hx(s));
    end
    q1.delete();
    do_start(1, 10'd1023, 1'b0);
    wait_idle(1, ok);
    s = qs(1);
    nvec++;
    if (!ok || s != "999cm\015\012") begin
      nerr++;
      $display("FAIL clamp1023 ok=%b got=%s exp=39 39 39 63 6d 0d 0a",
               ok, hx(s));
    end
  endtask

  task automatic test_no_units;
    bit ok;
    string s;
    q2.delete();
    do_start(2, 10'd12, 1'b0);
    wait_idle(2, ok);
    s = qs(2);
    nvec++;
    if (!ok || s != "12\015\012") begin
      nerr++;
      $display("FAIL no_units ok=%b got=%s exp=31 32 0d 0a",
               ok, hx(s));
    end
  endtask

  task automatic test_stall;
    bit ok;
    string s;
    int n;
    int sw;
    q0.delete();
    do_start(0, 10'd105, 1'b0);
    n = 0;
    for (int k = 0; k < 100 && n < 2; k++) begin
      @(negedge clk);
      if (we0) n++;
    end
    fifo_full = 1'b1;
    sw = 0;
    repeat (20) begin
      @(negedge clk);
      if (we0) sw++;
    end
    fifo_full = 1'b0;
    nvec++;
    if (n != 2 || sw != 0) begin
      nerr++;
      $display("FAIL stall_we got=%0d/%0d exp=2/0", n, sw);
    end
    wait_idle(0, ok);
    s = qs(0);
    nvec++;
    if (!ok || s != "105cm\015\012") begin
      nerr++;
      $display("FAIL stall_seq ok=%b got=%s exp=31 30 35 63 6d 0d 0a",
               ok, hx(s));
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    string s;
    q0.delete();
    do_start(0, 10'd7, 1'b0);
    do_start(0, 10'd88, 1'b0);
    wait_idle(0, ok);
    s = qs(0);
    nvec++;
    if (!ok || s != "7cm\015\012") begin
      nerr++;
      $display("FAIL busy_start ok=%b got=%s exp=37 63 6d 0d 0a",
               ok, hx(s));
    end
    q0.delete();
    do_start(0, 10'd42, 1'b0);
    nvec++;
    if (busy0 !== 1'b1) begin
      nerr++;
      $display("FAIL restart_busy got=%b exp=1", busy0);
    end
    wait_idle(0, ok);
    s = qs(0);
    nvec++;
    if (!ok || s != "42cm\015\012") begin
      nerr++;
      $display("FAIL restart_seq ok=%b got=%s exp=34 32 63 6d 0d 0a",
               ok, hx(s));
    end
  endtask

  task automatic test_mid_reset;
    int n;
    q0.delete();
    do_start(0, 10'd105, 1'b0);
    n = 0;
    for (int k = 0; k < 100 && n < 2; k++) begin
      @(negedge clk);
      if (we0) n++;
    end
    reset = 1'b1;
    #1;
    nvec++;
    if (n != 2 || we0 !== 1'b0 || busy0 !== 1'b0 ||
        tx0 !== 8'h00) begin
      nerr++;
      $display("FAIL mid_rst n=%0d we=%b busy=%b tx=%h exp=2/0/0/00",
               n, we0, busy0, tx0);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    nvec++;
    if (q0.size() != 2 || busy0 !== 1'b0) begin
      nerr++;
      $display("FAIL post_rst bytes=%0d busy=%b exp=2/0",
               q0.size(), busy0);
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_error();
    test_clamp();
    test_no_units();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
